prng_bcd_display: RTL and testbench

- Downstream consumer of the 12-bit pseudo-random generator output.
- On a debounced press of button A, it snapshots the random value and converts it to 4-digit BCD with a sequential double-dabble engine.
- It drives a 4-digit, time-multiplexed, active-low 7-segment display with leading-zero blanking.
- This is the board-visible end of the random-number chain.

---
 rtl/prng_bcd_display_if.sv | 36 +++
 rtl/prng_bcd_display.sv | 184 ++++++++++++++++++
 tb/tb_prng_bcd_display.sv | 310 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prng_bcd_display_if.sv
// Signal bundle between the button/random-source side and the BCD display block.
// The master side drives the button and random value; the slave side owns the display.
interface prng_bcd_display_if;
   localparam int unsigned IN_W  = 12;
   localparam int unsigned BCD_W = 16;
   localparam int unsigned AN_W  = 4;
   localparam int unsigned SEG_W = 7;

   logic             A;
   logic [IN_W-1:0]  rand_in;
   logic             busy;
   logic             value_valid;
   logic [BCD_W-1:0] bcd;
   logic [AN_W-1:0]  an;
   logic [SEG_W-1:0] seg;

   modport master (
      output A,
      output rand_in,
      input  busy,
      input  value_valid,
      input  bcd,
      input  an,
      input  seg
   );

   modport slave (
      input  A,
      input  rand_in,
      output busy,
      output value_valid,
      output bcd,
      output an,
      output seg
   );
endinterface

// File: rtl/prng_bcd_display.sv
// Snapshots the random value on a debounced press of A, converts it to BCD with a
// sequential double-dabble engine and shows it on a multiplexed 4-digit 7-segment display.
module prng_bcd_display #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned REFRESH_CYCLES  = 100000
) (
   input  logic               clk,
   input  logic               rst,
   prng_bcd_display_if.slave  bus
);
   localparam int unsigned IN_W   = 12;
   localparam int unsigned BCD_W  = 16;
   localparam int unsigned ITERS  = 12;
   localparam int unsigned IT_W   = 4;
   localparam int unsigned DIG_W  = 4;
   localparam int unsigned IDX_W  = 2;
   localparam int unsigned SEG_W  = 7;
   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int unsigned REF_W  = (REFRESH_CYCLES > 1) ? $clog2(REFRESH_CYCLES) : 1;

   typedef enum logic [1:0] {IDLE, SHIFT, LATCH} state_t;

   state_t            state, state_d;
   logic              a_meta, a_sync;
   logic              db_level, capture;
   logic [DB_W-1:0]   db_cnt;
   logic              load_c, shift_c, latch_c;
   logic [IN_W-1:0]   shreg;
   logic [BCD_W-1:0]  scratch, scratch_adj;
   logic [IT_W-1:0]   iter;
   logic [REF_W-1:0]  ref_cnt;
   logic [IDX_W-1:0]  idx;
   logic [DIG_W-1:0]  digit_c;
   logic              lead_zero, blank_c;

   // Two-flop synchronizer for the raw button
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         a_meta <= 1'b0;
         a_sync <= 1'b0;
      end else begin
         a_meta <= bus.A;
         a_sync <= a_meta;
      end
   end

   // Level follows a_sync only after a full run of disagreeing cycles; rising flip pulses capture
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
         capture  <= 1'b0;
      end else begin
         capture <= 1'b0;
         if (a_sync == db_level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            db_level <= a_sync;
            db_cnt   <= '0;
            capture  <= a_sync;
         end else begin
            db_cnt <= db_cnt + DB_W'(1);
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_d;
   end

   // Capture pulses outside IDLE are ignored, so presses during a conversion are dropped
   always_comb begin
      state_d = state;
      load_c  = 1'b0;
      shift_c = 1'b0;
      latch_c = 1'b0;
      unique case (state)
         IDLE: begin
            if (capture) begin
               load_c  = 1'b1;
               state_d = SHIFT;
            end
         end
         SHIFT: begin
            shift_c = 1'b1;
            if (iter == IT_W'(ITERS - 1)) state_d = LATCH;
         end
         LATCH: begin
            latch_c = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // Add-3 correction on every nibble that would overflow a decimal digit once doubled
   always_comb begin
      scratch_adj = scratch;
      for (int i = 0; i < 4; i++) begin
         if (scratch[4*i +: 4] >= 4'd5) scratch_adj[4*i +: 4] = scratch[4*i +: 4] + 4'd3;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         shreg           <= '0;
         scratch         <= '0;
         iter            <= '0;
         bus.busy        <= 1'b0;
         bus.value_valid <= 1'b0;
         bus.bcd         <= '0;
      end else begin
         if (load_c) begin
            shreg    <= bus.rand_in;
            scratch  <= '0;
            iter     <= '0;
            bus.busy <= 1'b1;
         end
         if (shift_c) begin
            {scratch, shreg} <= {scratch_adj[BCD_W-2:0], shreg, 1'b0};
            iter             <= iter + IT_W'(1);
         end
         if (latch_c) begin
            bus.bcd         <= scratch;
            bus.value_valid <= 1'b1;
            bus.busy        <= 1'b0;
         end
      end
   end

   // Scan timer: each digit slot stays enabled for REFRESH_CYCLES clocks
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_cnt <= '0;
         idx     <= '0;
      end else if (ref_cnt == REF_W'(REFRESH_CYCLES - 1)) begin
         ref_cnt <= '0;
         idx     <= idx + IDX_W'(1);
      end else begin
         ref_cnt <= ref_cnt + REF_W'(1);
      end
   end

   function automatic logic [SEG_W-1:0] seg_code(input logic [DIG_W-1:0] d);
      logic [SEG_W-1:0] s;
      unique case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // A slot is blanked when the value is not yet valid or it is a leading zero
   always_comb begin
      digit_c = bus.bcd[4*idx +: 4];
      unique case (idx)
         2'd0:    lead_zero = 1'b0;
         2'd1:    lead_zero = (bus.bcd[15:4] == 12'h000);
         2'd2:    lead_zero = (bus.bcd[15:8] == 8'h00);
         default: lead_zero = (bus.bcd[15:12] == 4'h0);
      endcase
      blank_c = !bus.value_valid || lead_zero;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.an  <= 4'b1111;
         bus.seg <= 7'h7F;
      end else begin
         bus.an  <= blank_c ? 4'b1111 : ~(4'b0001 << idx);
         bus.seg <= blank_c ? 7'h7F : seg_code(digit_c);
      end
   end
endmodule

// File: tb/tb_prng_bcd_display.sv
// Randomized self-checking bench for prng_bcd_display against a decimal-arithmetic model.
module tb_prng_bcd_display;
   localparam int unsigned DEB = 4;
   localparam int unsigned REF = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   prng_bcd_display_if bus ();

   prng_bcd_display #(.DEBOUNCE_CYCLES(DEB), .REFRESH_CYCLES(REF)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Model state: last completed conversion
   int model_val   = 0;
   bit model_valid = 1'b0;

   logic [6:0] seg_tab [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                                7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

   // Busy window monitor; a reset-aborted window is not counted
   int   windows  = 0;
   int   cur_len  = 0;
   int   last_len = 0;
   logic busy_q   = 1'b0;
   always @(negedge clk) begin
      if (rst) begin
         cur_len <= 0;
         busy_q  <= 1'b0;
      end else begin
         if (bus.busy) cur_len <= cur_len + 1;
         else if (busy_q) begin
            windows  <= windows + 1;
            last_len <= cur_len;
            cur_len  <= 0;
         end
         busy_q <= bus.busy;
      end
   end

   function automatic int pow10(input int k);
      int p = 1;
      for (int i = 0; i < k; i++) p = p * 10;
      return p;
   endfunction

   function automatic logic [15:0] bcd_model(input int v);
      return {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
   endfunction

   task automatic check_scan(input string tag);
      bit seen [4];
      int n_blank = 0;
      int slot;
      bit any_blank;
      for (int k = 0; k < 4; k++) seen[k] = 1'b0;
      for (int c = 0; c < 4 * REF + 8; c++) begin
         @(negedge clk);
         slot = -1;
         for (int k = 0; k < 4; k++) if (bus.an === 4'(~(4'b0001 << k))) slot = k;
         checks++;
         if (bus.an === 4'b1111) begin
            n_blank++;
            if (bus.seg !== 7'h7F) begin
               errors++;
               $display("FAIL %s blank_seg: seg=%h expected 7f", tag, bus.seg);
            end
         end else if (slot < 0) begin
            errors++;
            $display("FAIL %s an_legal: an=%b expected one-hot-low or 1111", tag, bus.an);
         end else if (!(model_valid && (slot == 0 || model_val >= pow10(slot)))) begin
            errors++;
            $display("FAIL %s blanking: slot %0d lit an=%b expected 1111 (val=%0d valid=%0b)",
                     tag, slot, bus.an, model_val, model_valid);
         end else begin
            seen[slot] = 1'b1;
            if (bus.seg !== seg_tab[(model_val / pow10(slot)) % 10]) begin
               errors++;
               $display("FAIL %s seg_slot%0d: seg=%h expected %h", tag, slot, bus.seg,
                        seg_tab[(model_val / pow10(slot)) % 10]);
            end
         end
      end
      any_blank = 1'b0;
      for (int k = 0; k < 4; k++) begin
         if (model_valid && (k == 0 || model_val >= pow10(k))) begin
            checks++;
            if (!seen[k]) begin
               errors++;
               $display("FAIL %s slot_seen%0d: slot never lit, expected lit for val=%0d",
                        tag, k, model_val);
            end
         end else any_blank = 1'b1;
      end
      if (any_blank) begin
         checks++;
         if (n_blank == 0) begin
            errors++;
            $display("FAIL %s blank_seen: blank cycles=0 expected >0", tag);
         end
      end
   endtask

   task automatic check_result(input int w0, input string tag);
      checks++;
      if (windows !== w0 + 1) begin
         errors++;
         $display("FAIL %s windows: got %0d expected %0d", tag, windows - w0, 1);
      end
      checks++;
      if (last_len !== 13) begin
         errors++;
         $display("FAIL %s busy_len: got %0d expected 13", tag, last_len);
      end
      checks++;
      if (bus.bcd !== bcd_model(model_val)) begin
         errors++;
         $display("FAIL %s bcd: got %h expected %h", tag, bus.bcd, bcd_model(model_val));
      end
      checks++;
      if (bus.value_valid !== model_valid || bus.busy !== 1'b0) begin
         errors++;
         $display("FAIL %s valid_busy: valid=%b busy=%b expected valid=%b busy=0",
                  tag, bus.value_valid, bus.busy, model_valid);
      end
   endtask

   task automatic do_capture(input int v, input string tag);
      int w0 = windows;
      @(negedge clk);
      bus.rand_in = 12'(v);
      bus.A       = 1'b1;
      repeat (12) @(negedge clk);
      bus.A = 1'b0;
      repeat (30) @(negedge clk);
      model_val   = v;
      model_valid = 1'b1;
      check_result(w0, tag);
   endtask

   task automatic wait_busy(input string tag, output bit ok);
      int t = 0;
      while (bus.busy !== 1'b1 && t < 40) begin
         @(negedge clk);
         t++;
      end
      ok = (bus.busy === 1'b1);
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s busy_timeout: busy=%b expected 1 within 40 cycles", tag, bus.busy);
      end
   endtask

   task automatic test_reset();
      bit ok;
      int w0;
      bus.A       = 1'b1;
      bus.rand_in = 12'hFFF;
      rst         = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         checks++;
         if ({bus.busy, bus.value_valid, bus.bcd, bus.an, bus.seg} !==
             {1'b0, 1'b0, 16'h0000, 4'b1111, 7'h7F}) begin
            errors++;
            $display("FAIL reset_state: busy=%b valid=%b bcd=%h an=%b seg=%h expected 0 0 0000 1111 7f",
                     bus.busy, bus.value_valid, bus.bcd, bus.an, bus.seg);
         end
      end
      w0  = windows;
      rst = 1'b0;
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         checks++;
         if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_early_capture: cycle %0d busy=%b expected 0", c, bus.busy);
         end
      end
      wait_busy("reset_release", ok);
      bus.A = 1'b0;
      repeat (30) @(negedge clk);
      model_val   = 4095;
      model_valid = 1'b1;
      check_result(w0, "cap_4095");
      check_scan("scan_4095");
   endtask

   task automatic test_boundaries();
      do_capture(1023, "cap_1023");
      check_scan("scan_1023");
      do_capture(0, "cap_0");
      check_scan("scan_0");
      do_capture(7, "cap_7");
      check_scan("scan_7");
   endtask

   task automatic test_bounce();
      int  w0 = windows;
      bit  saw_busy = 1'b0;
      for (int i = 0; i < 20; i++) begin
         bus.A = (i % 2 == 0);
         repeat (2) begin
            @(negedge clk);
            if (bus.busy === 1'b1) saw_busy = 1'b1;
         end
      end
      bus.A = 1'b0;
      repeat (20) begin
         @(negedge clk);
         if (bus.busy === 1'b1) saw_busy = 1'b1;
      end
      checks++;
      if (saw_busy || windows !== w0) begin
         errors++;
         $display("FAIL bounce_capture: busy_seen=%b windows=%0d expected 0 0",
                  saw_busy, windows - w0);
      end
      checks++;
      if (bus.bcd !== bcd_model(model_val)) begin
         errors++;
         $display("FAIL bounce_bcd: got %h expected %h", bus.bcd, bcd_model(model_val));
      end
   endtask

   task automatic test_busy_drop();
      int w0 = windows;
      bit ok;
      @(negedge clk);
      bus.rand_in = 12'd512;
      fork
         begin
            // second debounced rise lands eight cycles into the conversion
            bus.A = 1'b1; repeat (4) @(negedge clk);
            bus.A = 1'b0; repeat (4) @(negedge clk);
            bus.A = 1'b1; repeat (8) @(negedge clk);
            bus.A = 1'b0;
         end
         begin
            wait_busy("drop_start", ok);
            if (ok) begin
               repeat (3) @(posedge clk);
               #1 bus.rand_in = 12'd99;
            end
         end
      join
      repeat (30) @(negedge clk);
      model_val   = 512;
      model_valid = 1'b1;
      check_result(w0, "busy_drop");
      check_scan("scan_512");
   endtask

   task automatic test_reset_mid();
      bit ok;
      do_capture(305, "cap_305");
      @(negedge clk);
      bus.rand_in = 12'd777;
      bus.A       = 1'b1;
      wait_busy("mid_start", ok);
      repeat (6) @(posedge clk);
      #1 rst = 1'b1;
      bus.A = 1'b0;
      model_val   = 0;
      model_valid = 1'b0;
      @(negedge clk);
      checks++;
      if ({bus.busy, bus.value_valid, bus.bcd, bus.an, bus.seg} !==
          {1'b0, 1'b0, 16'h0000, 4'b1111, 7'h7F}) begin
         errors++;
         $display("FAIL mid_reset_state: busy=%b valid=%b bcd=%h an=%b seg=%h expected 0 0 0000 1111 7f",
                  bus.busy, bus.value_valid, bus.bcd, bus.an, bus.seg);
      end
      @(negedge clk);
      rst = 1'b0;
      check_scan("scan_after_abort");
      do_capture(42, "cap_42");
      check_scan("scan_42");
   endtask

   task automatic test_random();
      int v;
      for (int i = 0; i < 6; i++) begin
         v = int'($urandom_range(0, 4095));
         do_capture(v, "cap_random");
         check_scan("scan_random");
      end
   endtask

   initial begin
      bus.A       = 1'b1;
      bus.rand_in = 12'hFFF;
      test_reset();
      test_boundaries();
      test_bounce();
      test_busy_drop();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
